// File: rtl/edit_mem_buf_free_list_pkg.sv
// edit_mem_buf_free_list_pkg: shared widths and FSM encodings for the edit-memory buffer free list
package edit_mem_buf_free_list_pkg;
  localparam int EM_BUF_PTR_NBITS = 4;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} fl_state_e;
endpackage

// File: rtl/edit_mem_buf_free_list_ram_1r1w.sv
// edit_mem_buf_free_list_ram_1r1w: 1-read 1-write RAM with a registered read port, free-list storage
module edit_mem_buf_free_list_ram_1r1w #(
  parameter int AW    = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [2**AW];
  logic [WIDTH-1:0] rdata_q;
  // write port and registered read port; read data is valid the cycle after re_i
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/edit_mem_buf_free_list.sv
// edit_mem_buf_free_list: buffer-pointer free list (RAM FIFO + 2-entry prefetch); EM_FREE_LIST_DOUBLE_FREE_CHK_EN adds a double-free bitmap
module edit_mem_buf_free_list
  import edit_mem_buf_free_list_pkg::*;
#(
  parameter int BPTR_NBITS = EM_BUF_PTR_NBITS
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  em_rel_buf_valid,
  input  logic [BPTR_NBITS-1:0] em_rel_buf_ptr,
  input  logic                  buf_alloc,
  output logic                  buf_avail,
  output logic [BPTR_NBITS-1:0] buf_alloc_ptr,
  output logic [BPTR_NBITS:0]   free_cnt,
  output logic                  init_done,
  output logic                  err_alloc_empty,
  output logic                  err_double_free
);
  localparam int NUM_BUFS = 2**BPTR_NBITS;
  typedef logic [BPTR_NBITS-1:0] ptr_t;
  typedef logic [BPTR_NBITS:0]   cnt_t;

  fl_state_e  state_q, state_d;
  ptr_t       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t       ram_cnt_q, ram_cnt_d, free_cnt_q, free_cnt_d;
  ptr_t       head_q, head_d, next_q, next_d;
  logic [1:0] pf_cnt_q, pf_cnt_d;
  logic       infl_q, infl_d, avail_q, avail_d, init_done_q, init_done_d, err_ae_q, err_ae_d;
  logic       run, pop, rel_ok, bypass, ram_we, ram_re, push;
  logic [1:0] pf_left;
  ptr_t       ram_rdata, ram_wdata, push_val;

  assign run = state_q == ST_RUN;
  assign pop = run && buf_alloc && avail_q;
`ifdef EM_FREE_LIST_DOUBLE_FREE_CHK_EN
  logic [NUM_BUFS-1:0] bmap_q, bmap_d;
  logic                err_df_q, err_df_d;
  assign rel_ok = run && em_rel_buf_valid && bmap_q[em_rel_buf_ptr];
  // allocated bitmap: alloc marks the head pointer, an accepted release clears it
  always_comb begin
    bmap_d = bmap_q;
    if (pop) bmap_d[head_q] = 1'b1;
    if (rel_ok) bmap_d[em_rel_buf_ptr] = 1'b0;
    err_df_d = err_df_q || (em_rel_buf_valid && !rel_ok);
  end
  // bitmap and sticky double-free flag registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bmap_q   <= '0;
      err_df_q <= 1'b0;
    end else begin
      bmap_q   <= bmap_d;
      err_df_q <= err_df_d;
    end
  end
  assign err_double_free = err_df_q;
`else
  assign rel_ok = run && em_rel_buf_valid;
  assign err_double_free = 1'b0;
`endif

  assign pf_left   = pf_cnt_q - {1'b0, pop};
  assign bypass    = rel_ok && ram_cnt_q == '0 && !infl_q && pf_left != 2'd2;
  assign ram_we    = !run || (rel_ok && !bypass);
  assign ram_wdata = run ? em_rel_buf_ptr : wr_ptr_q;
  assign ram_re    = run && ram_cnt_q != '0 && (pf_left + {1'b0, infl_q}) < 2'd2;
  assign push      = infl_q || bypass;
  assign push_val  = infl_q ? ram_rdata : em_rel_buf_ptr;

  edit_mem_buf_free_list_ram_1r1w #(.AW(BPTR_NBITS), .WIDTH(BPTR_NBITS)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // next state: INIT fills the RAM with 0..NUM_BUFS-1, RUN moves pointers RAM -> prefetch -> consumer
  always_comb begin
    state_d     = (!run && wr_ptr_q == ptr_t'(NUM_BUFS - 1)) ? ST_RUN : state_q;
    init_done_d = init_done_q || state_d == ST_RUN;
    wr_ptr_d    = wr_ptr_q + ptr_t'(ram_we);
    rd_ptr_d    = rd_ptr_q + ptr_t'(ram_re);
    ram_cnt_d   = ram_cnt_q + cnt_t'(ram_we) - cnt_t'(ram_re);
    infl_d      = ram_re;
    head_d      = (push && pf_left == 2'd0) ? push_val : (pop ? next_q : head_q);
    next_d      = (push && pf_left == 2'd1) ? push_val : next_q;
    pf_cnt_d    = pf_left + {1'b0, push};
    avail_d     = pf_cnt_d != 2'd0;
    free_cnt_d  = free_cnt_q + cnt_t'(!run || rel_ok) - cnt_t'(pop);
    err_ae_d    = err_ae_q || (buf_alloc && !avail_q);
  end

  // state registers; reset discards everything and restarts INIT
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_INIT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      free_cnt_q  <= '0;
      head_q      <= '0;
      next_q      <= '0;
      pf_cnt_q    <= '0;
      infl_q      <= 1'b0;
      avail_q     <= 1'b0;
      init_done_q <= 1'b0;
      err_ae_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      free_cnt_q  <= free_cnt_d;
      head_q      <= head_d;
      next_q      <= next_d;
      pf_cnt_q    <= pf_cnt_d;
      infl_q      <= infl_d;
      avail_q     <= avail_d;
      init_done_q <= init_done_d;
      err_ae_q    <= err_ae_d;
    end
  end

  assign buf_avail       = avail_q;
  assign buf_alloc_ptr   = head_q;
  assign free_cnt        = free_cnt_q;
  assign init_done       = init_done_q;
  assign err_alloc_empty = err_ae_q;
endmodule

// File: tb/tb_edit_mem_buf_free_list.sv
// tb_edit_mem_buf_free_list: randomized and directed checks of the free list against a queue model
module tb_edit_mem_buf_free_list;
  localparam int NB = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          em_rel_buf_valid = 1'b0;
  logic [NB-1:0] em_rel_buf_ptr = '0;
  logic          buf_alloc = 1'b0;
  logic          buf_avail;
  logic [NB-1:0] buf_alloc_ptr;
  logic [NB:0]   free_cnt;
  logic          init_done, err_alloc_empty, err_double_free;

  int passed = 0;
  int total  = 0;
  int free_q[$];
  bit alloc_set[N];

  always #5 clk = ~clk;

  edit_mem_buf_free_list #(.BPTR_NBITS(NB)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .em_rel_buf_valid (em_rel_buf_valid),
    .em_rel_buf_ptr   (em_rel_buf_ptr),
    .buf_alloc        (buf_alloc),
    .buf_avail        (buf_avail),
    .buf_alloc_ptr    (buf_alloc_ptr),
    .free_cnt         (free_cnt),
    .init_done        (init_done),
    .err_alloc_empty  (err_alloc_empty),
    .err_double_free  (err_double_free)
  );

  // one clock of stimulus; the model takes a pointer from the queue front and appends releases
  task automatic cyc(input bit a, input bit r, input int p);
    bit acc;
    int id;
    acc = a && buf_avail === 1'b1;
    buf_alloc = a;
    em_rel_buf_valid = r;
    em_rel_buf_ptr = NB'(p);
    @(posedge clk);
    #1;
    buf_alloc = 1'b0;
    em_rel_buf_valid = 1'b0;
    if (acc && free_q.size() > 0) begin
      id = free_q.pop_front();
      alloc_set[id] = 1'b1;
    end
    if (r && alloc_set[p]) begin
      alloc_set[p] = 1'b0;
      free_q.push_back(p);
    end
  endtask

  task automatic reset_and_init(input string tag);
    int t_done, t_avail;
    rstn = 1'b0;
    buf_alloc = 1'b0;
    em_rel_buf_valid = 1'b0;
    @(posedge clk);
    #1;
    total++; if (buf_avail !== 1'b0) $display("FAIL %s rst_avail got %0b exp 0", tag, buf_avail); else passed++;
    total++; if (buf_alloc_ptr !== '0) $display("FAIL %s rst_ptr got %0d exp 0", tag, buf_alloc_ptr); else passed++;
    total++; if (free_cnt !== '0) $display("FAIL %s rst_free got %0d exp 0", tag, free_cnt); else passed++;
    total++; if (init_done !== 1'b0) $display("FAIL %s rst_init_done got %0b exp 0", tag, init_done); else passed++;
    total++; if ({err_alloc_empty, err_double_free} !== 2'b00) $display("FAIL %s rst_err got %b exp 00", tag, {err_alloc_empty, err_double_free}); else passed++;
    @(negedge clk);
    rstn = 1'b1;
    t_done = -1;
    t_avail = -1;
    for (int c = 1; c <= 60 && t_avail < 0; c++) begin
      @(posedge clk);
      #1;
      if (init_done === 1'b1 && t_done < 0) t_done = c;
      if (buf_avail === 1'b1) t_avail = c;
    end
    total++; if (t_done != N) $display("FAIL %s init_done_cycle got %0d exp %0d", tag, t_done, N); else passed++;
    total++; if (t_avail != N + 2) $display("FAIL %s avail_cycle got %0d exp %0d", tag, t_avail, N + 2); else passed++;
    total++; if (buf_alloc_ptr !== NB'(0)) $display("FAIL %s first_ptr got %0d exp 0", tag, buf_alloc_ptr); else passed++;
    total++; if (free_cnt !== (NB+1)'(N)) $display("FAIL %s init_free got %0d exp %0d", tag, free_cnt, N); else passed++;
    free_q.delete();
    for (int i = 0; i < N; i++) begin
      free_q.push_back(i);
      alloc_set[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_and_init("reset");
  endtask

  task automatic test_drain();
    for (int i = 0; i < N; i++) begin
      total++; if (buf_avail !== 1'b1 || buf_alloc_ptr !== NB'(i)) $display("FAIL drain_%0d got avail=%0b ptr=%0d exp avail=1 ptr=%0d", i, buf_avail, buf_alloc_ptr, i); else passed++;
      cyc(1, 0, 0);
    end
    total++; if (buf_avail !== 1'b0) $display("FAIL drain_avail got %0b exp 0", buf_avail); else passed++;
    total++; if (free_cnt !== '0) $display("FAIL drain_free got %0d exp 0", free_cnt); else passed++;
  endtask

  task automatic test_bypass();
    cyc(0, 1, 7);
    total++; if (buf_avail !== 1'b1 || buf_alloc_ptr !== NB'(7)) $display("FAIL bypass got avail=%0b ptr=%0d exp avail=1 ptr=7", buf_avail, buf_alloc_ptr); else passed++;
    total++; if (free_cnt !== (NB+1)'(1)) $display("FAIL bypass_free got %0d exp 1", free_cnt); else passed++;
    cyc(1, 0, 0);
    total++; if (buf_avail !== 1'b0 || free_cnt !== '0) $display("FAIL bypass_realloc got avail=%0b free=%0d exp avail=0 free=0", buf_avail, free_cnt); else passed++;
  endtask

  task automatic test_alloc_empty();
    cyc(1, 0, 0);
    total++; if (err_alloc_empty !== 1'b1) $display("FAIL alloc_empty_err got %0b exp 1", err_alloc_empty); else passed++;
    total++; if (free_cnt !== '0) $display("FAIL alloc_empty_free got %0d exp 0", free_cnt); else passed++;
    cyc(0, 0, 0);
    total++; if (err_alloc_empty !== 1'b1 || buf_avail !== 1'b0) $display("FAIL alloc_empty_sticky got err=%0b avail=%0b exp err=1 avail=0", err_alloc_empty, buf_avail); else passed++;
  endtask

  task automatic test_simultaneous();
    int exp_order[5] = '{11, 12, 13, 14, 3};
    for (int p = 10; p <= 14; p++) cyc(0, 1, p);
    repeat (3) cyc(0, 0, 0);
    total++; if (free_cnt !== (NB+1)'(5) || buf_alloc_ptr !== NB'(10)) $display("FAIL simul_setup got free=%0d ptr=%0d exp free=5 ptr=10", free_cnt, buf_alloc_ptr); else passed++;
    cyc(1, 1, 3);
    total++; if (free_cnt !== (NB+1)'(5)) $display("FAIL simul_free got %0d exp 5", free_cnt); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++; if (buf_avail !== 1'b1 || buf_alloc_ptr !== NB'(exp_order[i])) $display("FAIL simul_order_%0d got avail=%0b ptr=%0d exp ptr=%0d", i, buf_avail, buf_alloc_ptr, exp_order[i]); else passed++;
      cyc(1, 0, 0);
    end
    total++; if (free_cnt !== '0) $display("FAIL simul_end_free got %0d exp 0", free_cnt); else passed++;
  endtask

  task automatic test_double_free();
`ifdef EM_FREE_LIST_DOUBLE_FREE_CHK_EN
    cyc(0, 1, 2);
    cyc(0, 1, 2);
    cyc(0, 0, 0);
    total++; if (err_double_free !== 1'b1) $display("FAIL dfree_err got %0b exp 1", err_double_free); else passed++;
`else
    cyc(0, 1, 2);
    cyc(0, 0, 0);
    total++; if (err_double_free !== 1'b0) $display("FAIL dfree_tied got %0b exp 0", err_double_free); else passed++;
`endif
    total++; if (free_cnt !== (NB+1)'(1) || buf_alloc_ptr !== NB'(2)) $display("FAIL dfree_state got free=%0d ptr=%0d exp free=1 ptr=2", free_cnt, buf_alloc_ptr); else passed++;
  endtask

  task automatic test_random();
    logic exp_df;
    int cand[$];
    bit a, r;
    int p;
    exp_df = err_double_free;
`ifndef EM_FREE_LIST_DOUBLE_FREE_CHK_EN
    exp_df = 1'b0;
`endif
    for (int it = 0; it < 400; it++) begin
      if (buf_avail === 1'b1) begin
        total++; if (free_q.size() == 0 || buf_alloc_ptr !== NB'(free_q[0])) $display("FAIL rand_head_%0d got %0d exp %0d", it, buf_alloc_ptr, free_q.size() ? free_q[0] : -1); else passed++;
      end
      cand.delete();
      for (int i = 0; i < N; i++) if (alloc_set[i]) cand.push_back(i);
      a = buf_avail === 1'b1 && $urandom_range(1) == 1;
      r = cand.size() > 0 && $urandom_range(1) == 1;
      p = r ? cand[$urandom_range(cand.size() - 1)] : 0;
      cyc(a, r, p);
      total++; if (free_cnt !== (NB+1)'(free_q.size())) $display("FAIL rand_free_%0d got %0d exp %0d", it, free_cnt, free_q.size()); else passed++;
    end
    repeat (4) cyc(0, 0, 0);
    total++; if (buf_avail !== (free_q.size() > 0)) $display("FAIL rand_settle_avail got %0b exp %0b", buf_avail, free_q.size() > 0); else passed++;
    total++; if (err_double_free !== exp_df) $display("FAIL rand_df got %0b exp %0b", err_double_free, exp_df); else passed++;
  endtask

  task automatic test_reset_mid();
    reset_and_init("reset_mid");
    for (int i = 0; i < 3; i++) begin
      total++; if (buf_alloc_ptr !== NB'(i)) $display("FAIL mid_ptr_%0d got %0d exp %0d", i, buf_alloc_ptr, i); else passed++;
      cyc(1, 0, 0);
    end
    total++; if (free_cnt !== (NB+1)'(N - 3)) $display("FAIL mid_free got %0d exp %0d", free_cnt, N - 3); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_drain();
    test_bypass();
    test_alloc_empty();
    test_simultaneous();
    test_double_free();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
